hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for an in-order issue stage.
// Each architectural register has a down-counter of cycles until its pending write
// lands in the register file. RAW and WAW hazards stall the presented instruction.
// Otherwise the counters give the forwarding stage select for each source.
// Optional feature: define SCOREBOARD_STATS_EN to count stall cycles on stall_cnt_o.
// Without it, stall_cnt_o is tied to zero.
module hazard_scoreboard #(
  parameter int unsigned AW      = 5,
  parameter int unsigned LW      = 3,
  parameter int unsigned WB_DIST = 2,
  localparam int unsigned CW     = $clog2(2**LW - 2 + WB_DIST + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rs1_i,
  input  logic [AW-1:0] issue_rs2_i,
  input  logic          issue_rs1_use_i,
  input  logic          issue_rs2_use_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic          issue_regwrite_i,
  input  logic [LW-1:0] issue_lat_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          issue_fire_o,
  output logic [CW-1:0] fwd_rs1_o,
  output logic [CW-1:0] fwd_rs2_o,
  output logic [31:0]   stall_cnt_o
);

  localparam int unsigned NREG = 2**AW;
  localparam logic [CW-1:0] WbDist = CW'(WB_DIST);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  logic [LW-1:0] lat_eff;
  logic [CW-1:0] load_val;
  logic [CW-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic          rs1_live, rs2_live, rd_live;
  logic          raw1, raw2, waw;

  // Hazard detection and forward selects from the current-cycle counters.
  always_comb begin
    // A latency of zero behaves like a single-cycle ALU op.
    lat_eff  = (issue_lat_i == '0) ? LW'(1) : issue_lat_i;
    load_val = CW'(lat_eff) - CW'(1) + WbDist;

    rs1_live = issue_rs1_use_i && (issue_rs1_i != '0);
    rs2_live = issue_rs2_use_i && (issue_rs2_i != '0);
    rd_live  = issue_regwrite_i && (issue_rd_i != '0);

    rs1_cnt  = cnt_q[issue_rs1_i];
    rs2_cnt  = cnt_q[issue_rs2_i];
    rd_cnt   = cnt_q[issue_rd_i];

    // Values within WB_DIST of write-back are already on a forwarding path.
    raw1     = rs1_live && (rs1_cnt > WbDist);
    raw2     = rs2_live && (rs2_cnt > WbDist);
    // An older write must not land after ours.
    waw      = rd_live && (rd_cnt > load_val);

    stall_o      = issue_valid_i & (raw1 | raw2 | waw);
    issue_fire_o = issue_valid_i & ~stall_o & ~flush_i;
    fwd_rs1_o    = rs1_live ? rs1_cnt : '0;
    fwd_rs2_o    = rs2_live ? rs2_cnt : '0;
  end

  // Next counter state: decrement all pending entries, then load the issuing rd.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    end
    if (issue_fire_o && rd_live) begin
      cnt_d[issue_rd_i] = load_val;
    end
    cnt_d[0] = '0;
  end

  // Counter registers; reset wins over any simultaneous issue.
  always_ff @(posedge clk_i) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rst_i) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (AW=5, LW=3, WB_DIST=2).
// Stimulus pushes the expected forward selects, the preceding stall-run length, and the
// stall statistic for every instruction it issues. A negedge monitor pops and checks one
// record per issue_fire_o.
module tb_hazard_scoreboard;

  localparam int unsigned AW = 5;
  localparam int unsigned LW = 3;
  localparam int unsigned CW = 4;

`ifdef SCOREBOARD_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct {
    string name;
    int    f1;
    int    f2;
    int    stalls;
    int    scnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          issue_valid_i = 1'b0;
  logic [AW-1:0] issue_rs1_i = '0;
  logic [AW-1:0] issue_rs2_i = '0;
  logic          issue_rs1_use_i = 1'b0;
  logic          issue_rs2_use_i = 1'b0;
  logic [AW-1:0] issue_rd_i = '0;
  logic          issue_regwrite_i = 1'b0;
  logic [LW-1:0] issue_lat_i = '0;
  logic          flush_i = 1'b0;
  logic          stall_o;
  logic          issue_fire_o;
  logic [CW-1:0] fwd_rs1_o;
  logic [CW-1:0] fwd_rs2_o;
  logic [31:0]   stall_cnt_o;

  int   checks = 0;
  int   errors = 0;
  int   stall_run = 0;
  exp_t exp_q[$];
  exp_t e;

  hazard_scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_rs1_use_i (issue_rs1_use_i),
    .issue_rs2_use_i (issue_rs2_use_i),
    .issue_rd_i      (issue_rd_i),
    .issue_regwrite_i(issue_regwrite_i),
    .issue_lat_i     (issue_lat_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .issue_fire_o    (issue_fire_o),
    .fwd_rs1_o       (fwd_rs1_o),
    .fwd_rs2_o       (fwd_rs2_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sc(input int v);
    return Stats ? v : 0;
  endfunction

  // Monitor: count stall cycles and check each fired instruction against the queue.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (stall_o) stall_run++;
      if (issue_fire_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_fwd1"}, int'(fwd_rs1_o), e.f1);
          chk({e.name, "_fwd2"}, int'(fwd_rs2_o), e.f2);
          chk({e.name, "_stalls"}, stall_run, e.stalls);
          chk({e.name, "_stallcnt"}, int'(stall_cnt_o), e.scnt);
        end
        stall_run = 0;
      end
    end else begin
      stall_run = 0;
    end
  end

  // Present one instruction, hold it until it fires (bounded), then drop valid.
  task automatic issue(input string name, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit rw, input int lat,
                       input int f1, input int f2, input int stalls, input int scnt);
    exp_t x;
    int   n;
    x.name = name; x.f1 = f1; x.f2 = f2; x.stalls = stalls; x.scnt = scnt;
    exp_q.push_back(x);
    issue_rs1_i      = AW'(rs1);
    issue_rs1_use_i  = u1;
    issue_rs2_i      = AW'(rs2);
    issue_rs2_use_i  = u2;
    issue_rd_i       = AW'(rd);
    issue_regwrite_i = rw;
    issue_lat_i      = LW'(lat);
    flush_i          = 1'b0;
    issue_valid_i    = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (issue_fire_o) break;
      n++;
    end
    if (n >= 20) chk({name, "_timeout"}, 1, 0);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Reset state with source reads presented but not valid.
    issue_rs1_i = 5'd5; issue_rs1_use_i = 1'b1;
    @(negedge clk);
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_fire", int'(issue_fire_o), 0);
    chk("rst_fwd1", int'(fwd_rs1_o), 0);
    chk("rst_stallcnt", int'(stall_cnt_o), 0);
    @(posedge clk);
    #1;

    // L=1 producer: back-to-back consumers see 2, 1, 0.
    issue("alu_prod", 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, sc(0));
    issue("alu_use1", 5, 1, 0, 0, 0, 0, 1, 2, 0, 0, sc(0));
    issue("alu_use2", 5, 1, 0, 0, 0, 0, 1, 1, 0, 0, sc(0));
    issue("alu_use3", 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, sc(0));
    idle(10);

    // L=2 producer: one stall, then forward 2 on rs2.
    issue("load_prod", 0, 0, 0, 0, 6, 1, 2, 0, 0, 0, sc(0));
    issue("load_use", 0, 0, 6, 1, 0, 0, 1, 0, 2, 1, sc(1));
    idle(10);

    // Writes to x0 are ignored; x0 and idle registers forward 0.
    issue("x0_prod", 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, sc(1));
    issue("x0_use", 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, sc(1));
    issue("idle_use", 1, 1, 31, 1, 0, 0, 1, 0, 0, 0, sc(1));
    idle(10);

    // WAW: cnt=5 blocks a V=2 write for 3 cycles; the new write then owns x7.
    issue("waw_prod", 0, 0, 0, 0, 7, 1, 4, 0, 0, 0, sc(1));
    issue("waw_write", 0, 0, 0, 0, 7, 1, 1, 0, 0, 3, sc(4));
    issue("waw_use", 7, 1, 0, 0, 0, 0, 1, 2, 0, 0, sc(4));
    idle(10);

    // rs == rd uses the pre-update count; latency 0 behaves as 1.
    issue("self_prod", 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, sc(4));
    issue("self_rw", 10, 1, 0, 0, 10, 1, 1, 2, 0, 0, sc(4));
    issue("self_use", 10, 1, 0, 0, 0, 0, 1, 2, 0, 0, sc(4));
    issue("lat0_prod", 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, sc(4));
    issue("lat0_use", 0, 0, 11, 1, 0, 0, 1, 0, 2, 0, sc(4));
    idle(10);

    // Reset with a load pending clears counters and the statistic.
    issue("rst_prod", 0, 0, 0, 0, 8, 1, 4, 0, 0, 0, sc(4));
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    issue("rst_use", 8, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(10);

    // Flushed write does not fire and leaves x9 idle.
    issue_rd_i = 5'd9; issue_regwrite_i = 1'b1; issue_lat_i = 3'd3;
    issue_rs1_use_i = 1'b0; issue_rs2_use_i = 1'b0;
    issue_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_fire", int'(issue_fire_o), 0);
    chk("flush_stall", int'(stall_o), 0);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0; flush_i = 1'b0;
    issue("flush_use", 9, 1, 9, 1, 0, 0, 1, 0, 0, 0, 0);
    idle(10);

    // Three WAW stall cycles after the reset show up in the statistic.
    issue("stat_prod", 0, 0, 0, 0, 12, 1, 4, 0, 0, 0, 0);
    issue("stat_write", 0, 0, 0, 0, 12, 1, 1, 0, 0, 3, sc(3));
    idle(10);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
